// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the IF stage, the program loader, the byte-wide memory
// and the imem port arbiter.
interface imem_port_arbiter_if #(parameter int ADDR_W = 7);
   logic              FetchReq;
   logic [31:0]       FetchAddr;
   logic [31:0]       Instruction;
   logic              FetchValid;
   logic              FetchErr;
   logic              FetchBusy;
   logic              LoadReq;
   logic [ADDR_W-1:0] LoadAddr;
   logic [7:0]        LoadData;
   logic              LoadAck;
   logic [ADDR_W-1:0] MemAddr;
   logic              MemWE;
   logic [7:0]        MemWrData;
   logic [7:0]        MemRdData;

   modport slave (
      input  FetchReq, FetchAddr, LoadReq, LoadAddr, LoadData, MemRdData,
      output Instruction, FetchValid, FetchErr, FetchBusy, LoadAck,
             MemAddr, MemWE, MemWrData
   );

   modport master (
      output FetchReq, FetchAddr, LoadReq, LoadAddr, LoadData, MemRdData,
      input  Instruction, FetchValid, FetchErr, FetchBusy, LoadAck,
             MemAddr, MemWE, MemWrData
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares one synchronous byte port between 4-beat MSB-first word fetches and
// single-byte loader writes, with round-robin arbitration on ties.
//
//  state | meaning
//  IDLE  | waiting; arbitrates between fetch and load
//  FETCH | beat counter cnt 0..4 issues 4 reads and collects the bytes
//  LOAD  | one-cycle byte write, LoadAck high
//  DONE  | FetchValid high; arbitrates again so the next grant costs no cycle
module imem_port_arbiter #(
   parameter int          MEM_BYTES = 128,
   parameter logic [31:0] HALT_WORD = 32'hFC000000
) (
   input logic               CLK,
   input logic               Reset,
   imem_port_arbiter_if.slave bus
);
   localparam int AW = $clog2(MEM_BYTES);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_FETCH = 2'd1;
   localparam logic [1:0] S_LOAD  = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic GNT_FETCH = 1'b0;
   localparam logic GNT_LOAD  = 1'b1;

   logic [1:0]    state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] base_q, base_d;
   logic [23:0]   asm_q, asm_d;
   logic [31:0]   instr_q, instr_d;
   logic          fvalid_q, fvalid_d;
   logic          ferr_q, ferr_d;
   logic          lack_q, lack_d;
   logic [AW-1:0] maddr_q, maddr_d;
   logic          mwe_q, mwe_d;
   logic [7:0]    mwdata_q, mwdata_d;
   logic          last_q, last_d;
   logic          grant_fetch, grant_load, fetch_oor;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      base_d      = base_q;
      asm_d       = asm_q;
      instr_d     = instr_q;
      fvalid_d    = 1'b0;
      ferr_d      = 1'b0;
      lack_d      = 1'b0;
      maddr_d     = maddr_q;
      mwe_d       = 1'b0;
      mwdata_d    = mwdata_q;
      last_d      = last_q;
      grant_fetch = bus.FetchReq && (!bus.LoadReq || last_q == GNT_LOAD);
      grant_load  = bus.LoadReq && !grant_fetch;
      fetch_oor   = |bus.FetchAddr[31:AW];

      case (state_q)
         S_IDLE, S_DONE: begin
            state_d = S_IDLE;
            if (grant_fetch) begin
               last_d = GNT_FETCH;
               if (fetch_oor) begin
                  // out-of-range fetch never touches memory
                  state_d  = S_DONE;
                  instr_d  = HALT_WORD;
                  fvalid_d = 1'b1;
                  ferr_d   = 1'b1;
               end else begin
                  state_d = S_FETCH;
                  cnt_d   = 3'd0;
                  base_d  = bus.FetchAddr[AW-1:0] & ~AW'(3);
                  maddr_d = bus.FetchAddr[AW-1:0] & ~AW'(3);
               end
            end else if (grant_load) begin
               last_d   = GNT_LOAD;
               state_d  = S_LOAD;
               maddr_d  = bus.LoadAddr;
               mwdata_d = bus.LoadData;
               mwe_d    = 1'b1;
               lack_d   = 1'b1;
            end
         end
         S_FETCH: begin
            cnt_d = cnt_q + 3'd1;
            if (cnt_q < 3'd3) maddr_d = base_q + AW'(cnt_q + 3'd1);
            // read data trails the address by one beat
            if (cnt_q == 3'd4) begin
               instr_d  = {asm_q, bus.MemRdData};
               fvalid_d = 1'b1;
               cnt_d    = 3'd0;
               state_d  = S_DONE;
            end else if (cnt_q != 3'd0) begin
               asm_d = {asm_q[15:0], bus.MemRdData};
            end
         end
         S_LOAD: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= 3'd0;
         base_q   <= '0;
         asm_q    <= '0;
         instr_q  <= '0;
         fvalid_q <= 1'b0;
         ferr_q   <= 1'b0;
         lack_q   <= 1'b0;
         maddr_q  <= '0;
         mwe_q    <= 1'b0;
         mwdata_q <= '0;
         last_q   <= GNT_LOAD;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         base_q   <= base_d;
         asm_q    <= asm_d;
         instr_q  <= instr_d;
         fvalid_q <= fvalid_d;
         ferr_q   <= ferr_d;
         lack_q   <= lack_d;
         maddr_q  <= maddr_d;
         mwe_q    <= mwe_d;
         mwdata_q <= mwdata_d;
         last_q   <= last_d;
      end
   end

   assign bus.Instruction = instr_q;
   assign bus.FetchValid  = fvalid_q;
   assign bus.FetchErr    = ferr_q;
   assign bus.FetchBusy   = (state_q != S_IDLE);
   assign bus.LoadAck     = lack_q;
   assign bus.MemAddr     = maddr_q;
   assign bus.MemWE       = mwe_q;
   assign bus.MemWrData   = mwdata_q;
endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_imem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_port_arbiter_if bus ();
   imem_port_arbiter #(.MEM_BYTES(128), .HALT_WORD(32'hFC000000)) dut (
      .CLK(clk), .Reset(rst), .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [128];
   logic [7:0] ref_mem [128];

   always @(posedge clk) begin
      if (bus.MemWE) mem[bus.MemAddr] <= bus.MemWrData;
      bus.MemRdData <= mem[bus.MemAddr];
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
      end
   endtask

   // ---------------- reference model: latency arithmetic + scheduled events
   bit          model_on = 0;
   int          cyc = 0;
   int          busy_left = 0;
   bit          last_load = 1;
   logic [31:0] e_instr = 0;
   bit          e_fv = 0, e_err = 0, e_la = 0, e_we = 0;
   logic [6:0]  e_addr = 0;
   logic [7:0]  e_wd = 0;
   logic [6:0]  addr_at [int];
   logic [31:0] fv_instr_at [int];

   initial begin
      forever begin
         bit          r, fr, lr, gf, gl;
         logic [31:0] fa;
         logic [6:0]  la;
         logic [7:0]  ld;
         int          b;
         @(posedge clk);
         r = rst; fr = bus.FetchReq; fa = bus.FetchAddr;
         lr = bus.LoadReq; la = bus.LoadAddr; ld = bus.LoadData;
         cyc++;
         if (r) begin
            model_on = 1; busy_left = 0; last_load = 1;
            e_instr = 0; e_fv = 0; e_err = 0; e_la = 0; e_we = 0; e_addr = 0; e_wd = 0;
            addr_at.delete(); fv_instr_at.delete();
         end else begin
            e_fv = 0; e_err = 0; e_la = 0; e_we = 0;
            if (addr_at.exists(cyc)) begin e_addr = addr_at[cyc]; addr_at.delete(cyc); end
            if (fv_instr_at.exists(cyc)) begin
               e_fv = 1; e_instr = fv_instr_at[cyc]; fv_instr_at.delete(cyc);
            end
            if (busy_left > 0) busy_left--;
            else begin
               gf = fr && (!lr || last_load);
               gl = lr && !gf;
               if (gf) begin
                  last_load = 0;
                  if (fa[31:7] != 0) begin
                     e_fv = 1; e_err = 1; e_instr = 32'hFC000000;
                  end else begin
                     b = int'(fa[6:0]) / 4 * 4;
                     e_addr = 7'(b);
                     for (int k = 1; k < 4; k++) addr_at[cyc + k] = 7'(b + k);
                     fv_instr_at[cyc + 5] = {ref_mem[b], ref_mem[b+1], ref_mem[b+2], ref_mem[b+3]};
                     busy_left = 5;
                  end
               end else if (gl) begin
                  last_load = 1;
                  e_addr = la; e_we = 1; e_wd = ld; e_la = 1;
                  ref_mem[la] = ld;
                  busy_left = 1;
               end
            end
         end
         #1;
         if (model_on) begin
            chk("m_instr", bus.Instruction, e_instr);
            chk("m_fvalid", 32'(bus.FetchValid), 32'(e_fv));
            chk("m_ferr", 32'(bus.FetchErr), 32'(e_err));
            chk("m_busy", 32'(bus.FetchBusy), 32'(busy_left > 0 || e_fv || e_la));
            chk("m_lack", 32'(bus.LoadAck), 32'(e_la));
            chk("m_maddr", 32'(bus.MemAddr), 32'(e_addr));
            chk("m_mwe", 32'(bus.MemWE), 32'(e_we));
            chk("m_mwdata", 32'(bus.MemWrData), 32'(e_wd));
         end
      end
   end

   // ---------------- directed helpers
   logic [6:0] addr_tr [1:20];

   task automatic do_fetch(input logic [31:0] a, output logic [31:0] instr,
                           output logic err, output int edges);
      @(negedge clk);
      bus.FetchReq = 1; bus.FetchAddr = a;
      edges = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         addr_tr[i] = bus.MemAddr;
         if (bus.FetchValid) begin edges = i; break; end
      end
      if (edges == 0) chk("fetch_timeout", 32'(bus.FetchValid), 32'd1);
      instr = bus.Instruction; err = bus.FetchErr;
      bus.FetchReq = 0;
   endtask

   task automatic do_load(input logic [6:0] a, input logic [7:0] d);
      int edges;
      @(negedge clk);
      bus.LoadReq = 1; bus.LoadAddr = a; bus.LoadData = d;
      edges = 0;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (bus.LoadAck) begin edges = i; break; end
      end
      chk("load_edges", 32'(edges), 32'd1);
      chk("load_we", 32'(bus.MemWE), 32'd1);
      bus.LoadReq = 0;
      @(negedge clk);
      chk("load_ack_single", 32'(bus.LoadAck), 32'd0);
   endtask

   initial begin
      logic [31:0] instr;
      logic        err;
      int          edges, fv_cnt, la_cnt;
      int          ev_kind [$];
      int          ev_cyc [$];

      for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h24; mem[1] = 8'h01; mem[2] = 8'h00; mem[3] = 8'h08;
      mem[4] = 8'h11; mem[5] = 8'h22; mem[6] = 8'h33; mem[7] = 8'h44;
      mem[28] = 8'h0C; mem[29] = 8'h00; mem[30] = 8'h00; mem[31] = 8'h14;
      for (int i = 0; i < 128; i++) ref_mem[i] = mem[i];
      bus.FetchReq = 0; bus.FetchAddr = 0; bus.LoadReq = 0; bus.LoadAddr = 0; bus.LoadData = 0;

      rst = 1;
      repeat (3) @(negedge clk);
      chk("rst_instr", bus.Instruction, 32'h0);
      chk("rst_maddr", 32'(bus.MemAddr), 32'h0);
      chk("rst_busy", 32'(bus.FetchBusy), 32'h0);
      rst = 0;

      do_fetch(32'h0, instr, err, edges);
      chk("basic_instr", instr, 32'h24010008);
      chk("basic_edges", 32'(edges), 32'd6);
      chk("basic_err", 32'(err), 32'd0);

      do_fetch(32'h1E, instr, err, edges);
      chk("align_instr", instr, 32'h0C000014);
      for (int k = 1; k <= 4; k++) chk("align_maddr", 32'(addr_tr[k]), 32'(27 + k));

      do_fetch(32'h80, instr, err, edges);
      chk("oor_instr", instr, 32'hFC000000);
      chk("oor_err", 32'(err), 32'd1);
      chk("oor_edges", 32'(edges), 32'd1);
      chk("oor_maddr", 32'(bus.MemAddr), 32'd31);

      do_load(7'd80, 8'hAC);
      do_load(7'd81, 8'h22);
      do_load(7'd82, 8'h00);
      do_load(7'd83, 8'h04);
      do_fetch(32'd80, instr, err, edges);
      chk("readback_instr", instr, 32'hAC220004);

      // both requesters held continuously from reset
      @(negedge clk);
      rst = 1;
      bus.FetchReq = 1; bus.FetchAddr = 32'd4;
      bus.LoadReq = 1; bus.LoadAddr = 7'd100; bus.LoadData = 8'h5A;
      @(negedge clk);
      rst = 0;
      for (int i = 1; i <= 30; i++) begin
         @(negedge clk);
         if (bus.FetchValid) begin ev_kind.push_back(1); ev_cyc.push_back(i); end
         if (bus.LoadAck)    begin ev_kind.push_back(2); ev_cyc.push_back(i); end
      end
      bus.FetchReq = 0; bus.LoadReq = 0;
      chk("alt_count", 32'(ev_kind.size() >= 4), 32'd1);
      if (ev_kind.size() >= 4) begin
         chk("alt_0", 32'(ev_kind[0]), 32'd1);
         chk("alt_1", 32'(ev_kind[1]), 32'd2);
         chk("alt_2", 32'(ev_kind[2]), 32'd1);
         chk("alt_3", 32'(ev_kind[3]), 32'd2);
         chk("alt_first_fv", 32'(ev_cyc[0]), 32'd6);
         chk("load_after_done", 32'(ev_cyc[1]), 32'd7);
      end
      repeat (8) @(negedge clk);

      // reset while the fetch is at cnt = 2
      bus.FetchReq = 1; bus.FetchAddr = 32'd0;
      repeat (3) @(negedge clk);
      chk("mid_maddr", 32'(bus.MemAddr), 32'd2);
      rst = 1; bus.FetchReq = 0;
      @(negedge clk);
      chk("mid_rst_busy", 32'(bus.FetchBusy), 32'd0);
      chk("mid_rst_instr", bus.Instruction, 32'h0);
      chk("mid_rst_maddr", 32'(bus.MemAddr), 32'h0);
      rst = 0;
      fv_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.FetchValid) fv_cnt++;
      end
      chk("mid_rst_no_valid", 32'(fv_cnt), 32'd0);

      // random traffic, checked by the model every cycle
      fv_cnt = 0; la_cnt = 0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (bus.FetchValid) fv_cnt++;
         if (bus.LoadAck) la_cnt++;
         rst = ($urandom % 400 == 0);
         if (bus.FetchReq && bus.FetchValid) bus.FetchReq = 0;
         else if (!bus.FetchReq && $urandom % 3 == 0) begin
            bus.FetchReq = 1;
            bus.FetchAddr = ($urandom % 8 == 0) ? ($urandom | 32'h80) : $urandom_range(0, 127);
         end else if (bus.FetchReq && $urandom % 50 == 0) bus.FetchReq = 0;
         if (bus.LoadReq && bus.LoadAck) bus.LoadReq = 0;
         else if (!bus.LoadReq && $urandom % 3 == 0) begin
            bus.LoadReq = 1;
            bus.LoadAddr = 7'($urandom_range(0, 127));
            bus.LoadData = 8'($urandom);
         end else if (bus.LoadReq && $urandom % 50 == 0) bus.LoadReq = 0;
      end
      rst = 0; bus.FetchReq = 0; bus.LoadReq = 0;
      repeat (10) @(negedge clk);
      chk("rand_fetch_activity", 32'(fv_cnt > 50), 32'd1);
      chk("rand_load_activity", 32'(la_cnt > 50), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
